fifo_sync_flex: RTL

Parametrised single-clock FIFO on inferred block or distributed RAM, the successor to our primitive-wrapped `fifo_sync`. It adds configurable width and depth, a selectable first-word-fall-through (FWFT) read mode, and programmable almost-full/almost-empty thresholds. It also provides an occupancy count and sticky overflow/underflow error flags. It sits between producer and consumer logic in one clock domain, for example on UART/DMA data paths.

---
 rtl/fifo_sync_flex.sv | 108 ++++++++++
 1 files changed

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO on an inferred RAM with a selectable standard or first-word-fall-through read port,
// programmable almost-full/almost-empty thresholds, an occupancy count and sticky error flags.
`timescale 1ns/1ps
module fifo_sync_flex #(
  parameter int WIDTH         = 32,
  parameter int DEPTH_LOG2    = 9,
  parameter bit FWFT          = 1'b0,
  parameter int AFULL_THRESH  = (1 << DEPTH_LOG2) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_reg, rptr_reg;
  logic [CW-1:0]         count_reg, count_next;
  logic [31:0]           count_ext;
  logic [WIDTH-1:0]      rd_data_reg;
  logic                  rd_valid_reg, rd_valid_next;
  logic                  full_reg, empty_reg, empty_next;
  logic                  afull_reg, aempty_reg;
  logic                  overflow_reg, underflow_reg;
  logic                  out_valid_reg, out_valid_next;
  logic                  wr_acc, rd_acc, ram_rd;

  assign wr_acc = wr_en && !full_reg;
  assign rd_acc = rd_en && !empty_reg;

  // In FWFT mode the output register is refilled whenever it is empty or being popped,
  // provided the RAM itself (count minus the prefetched word) still holds a word.
  always_comb begin
    ram_rd         = rd_acc;
    out_valid_next = 1'b0;
    if (FWFT) begin
      ram_rd         = (count_reg != CW'(out_valid_reg)) && (!out_valid_reg || rd_acc);
      out_valid_next = ram_rd || (out_valid_reg && !rd_acc);
    end
    count_next    = count_reg + CW'(wr_acc) - CW'(rd_acc);
    count_ext     = 32'(count_next);
    empty_next    = FWFT ? !out_valid_next : (count_next == '0);
    rd_valid_next = FWFT ? out_valid_next : ram_rd;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      count_reg     <= '0;
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      afull_reg     <= (AFULL_THRESH == 0);
      aempty_reg    <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_acc) wptr_reg <= wptr_reg + DEPTH_LOG2'(1);
      if (ram_rd) begin
        rptr_reg    <= rptr_reg + DEPTH_LOG2'(1);
        rd_data_reg <= mem[rptr_reg];
      end
      count_reg     <= count_next;
      rd_valid_reg  <= rd_valid_next;
      out_valid_reg <= out_valid_next;
      full_reg      <= (count_next == CW'(DEPTH));
      empty_reg     <= empty_next;
      afull_reg     <= (count_ext >= 32'(AFULL_THRESH));
      aempty_reg    <= (count_ext <= 32'(AEMPTY_THRESH));
      // A new error event takes priority over a clear in the same cycle.
      if (wr_en && full_reg)       overflow_reg <= 1'b1;
      else if (clr_err)            overflow_reg <= 1'b0;
      if (rd_en && empty_reg)      underflow_reg <= 1'b1;
      else if (clr_err)            underflow_reg <= 1'b0;
    end
  end

  assign rd_data      = rd_data_reg;
  assign rd_valid     = rd_valid_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = afull_reg;
  assign almost_empty = aempty_reg;
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;
endmodule
